riscv_test_harness: RTL

// - Parametrised simulation top for the single-cycle core: instruction memory loaded through a valid/ready port, byte-strobed data memory, run-control FSM.
// - Detects the test-result store, returns the pass/fail code, counts cycles, and aborts on a watchdog timeout.
// - Instantiates `core` and is the DUT top for the verification platform.

---
 rtl/riscv_test_harness.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_test_harness.sv
// Simulation top for the single-cycle RV32I core. It provides:
//   - instruction memory, loaded through a valid/ready programming port
//   - byte-strobed data memory
//   - a run-control FSM (PROG/RUN/DONE/TIMEOUT)
//   - capture of the test-result (tohost) store
//   - a saturating RUN-cycle counter and a watchdog
// Optional feature macro: RISCV_TEST_HARNESS_DMEM_PROG_EN adds a prog_target input.
// With prog_target=1, programming writes go to data memory instead of instruction memory.

// Single-cycle RV32I core (base integer subset, no CSRs or traps).
module core (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] addr,
  output logic        write_data,
  output logic [31:0] store_data,
  output logic [2:0]  funct3,
  input  logic [31:0] read_data
);
  typedef enum logic [6:0] {
    OP_LUI    = 7'h37,
    OP_AUIPC  = 7'h17,
    OP_JAL    = 7'h6F,
    OP_JALR   = 7'h67,
    OP_BRANCH = 7'h63,
    OP_LOAD   = 7'h03,
    OP_STORE  = 7'h23,
    OP_IMM    = 7'h13,
    OP_REG    = 7'h33
  } opcode_t;

  opcode_t     opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] op_b, alu_out, load_word, load_val, rd_val, next_pc;
  logic        rd_we, taken;
  logic [31:0] regs [32];

  assign opcode  = opcode_t'(instr[6:0]);
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u   = {instr[31:12], 12'h000};
  assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  // Effective address is computed apart from writeback so the load path has no loop.
  assign addr       = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign store_data = rs2_val;

  // Integer ALU shared by register and immediate forms.
  always_comb begin
    op_b    = (opcode == OP_REG) ? rs2_val : imm_i;
    alu_out = '0;
    case (funct3)
      3'd0:    alu_out = (opcode == OP_REG && instr[30]) ? rs1_val - op_b : rs1_val + op_b;
      3'd1:    alu_out = rs1_val << op_b[4:0];
      3'd2:    alu_out = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'd3:    alu_out = {31'd0, rs1_val < op_b};
      3'd4:    alu_out = rs1_val ^ op_b;
      3'd5:    alu_out = instr[30] ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
      3'd6:    alu_out = rs1_val | op_b;
      default: alu_out = rs1_val & op_b;
    endcase
  end

  // Branch condition and load byte/half extraction from the addressed word.
  always_comb begin
    taken     = 1'b0;
    load_word = read_data >> {addr[1:0], 3'b000};
    load_val  = load_word;
    case (funct3)
      3'd0:    taken = (rs1_val == rs2_val);
      3'd1:    taken = (rs1_val != rs2_val);
      3'd4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6:    taken = (rs1_val <  rs2_val);
      3'd7:    taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
    case (funct3)
      3'd0:    load_val = {{24{load_word[7]}}, load_word[7:0]};
      3'd1:    load_val = {{16{load_word[15]}}, load_word[15:0]};
      3'd4:    load_val = {24'd0, load_word[7:0]};
      3'd5:    load_val = {16'd0, load_word[15:0]};
      default: load_val = load_word;
    endcase
  end

  // Main decode: next pc, writeback value and store request.
  always_comb begin
    next_pc    = pc + 32'd4;
    rd_we      = 1'b0;
    rd_val     = '0;
    write_data = 1'b0;
    case (opcode)
      OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm_u; end
      OP_JAL:    begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = pc + imm_j; end
      OP_JALR:   begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = (rs1_val + imm_i) & ~32'd1; end
      OP_BRANCH: if (taken) next_pc = pc + imm_b;
      OP_LOAD:   begin rd_we = 1'b1; rd_val = load_val; end
      OP_STORE:  write_data = 1'b1;
      OP_IMM,
      OP_REG:    begin rd_we = 1'b1; rd_val = alu_out; end
      default:   ;
    endcase
  end

  // Program counter; rst is decoded from harness state, so it is sampled synchronously.
  always_ff @(posedge clk) begin
    if (rst) pc <= '0;
    else     pc <= next_pc;
  end

  // Register file writeback (x0 is never written).
  always_ff @(posedge clk) begin
    if (!rst && rd_we && rd != 5'd0) regs[rd] <= rd_val;
  end
endmodule

module riscv_test_harness #(
  parameter int unsigned INST_MEM_ADDR_SIZE = 12,
  parameter int unsigned DATA_MEM_ADDR_SIZE = 12,
  parameter logic [31:0] RESULT_ADDR        = 32'hFFFF_FFFC,
  parameter int unsigned TIMEOUT_CYCLES     = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          prog_valid,
  output logic                          prog_ready,
  input  logic [INST_MEM_ADDR_SIZE-3:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          prog_done,
`ifdef RISCV_TEST_HARNESS_DMEM_PROG_EN
  input  logic                          prog_target,
`endif
  output logic                          running,
  output logic                          result_valid,
  output logic                          result_passed,
  output logic [30:0]                   result_code,
  output logic                          timeout,
  output logic [31:0]                   cycle_count
);
  localparam int unsigned IMEM_WORDS   = 2 ** (INST_MEM_ADDR_SIZE - 2);
  localparam int unsigned DMEM_WORDS   = 2 ** (DATA_MEM_ADDR_SIZE - 2);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_PROG, ST_RUN, ST_DONE, ST_TIMEOUT} state_t;

  state_t      state, state_next;
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] pc, instr, addr, store_data, read_data, wdata;
  logic [2:0]  funct3;
  logic [3:0]  base_strobe, strobe;
  logic        write_data, core_rst, result_hit, timeout_hit, store_en, prog_wr;
  logic        unused_bits;

  assign core_rst    = !reset_n || (state != ST_RUN);
  assign instr       = imem[pc[INST_MEM_ADDR_SIZE-1:2]];
  assign read_data   = dmem[addr[DATA_MEM_ADDR_SIZE-1:2]];
  assign result_hit  = write_data && (addr[31:2] == RESULT_ADDR[31:2]) && (state == ST_RUN);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ST_RUN) && (cycle_count == TIMEOUT_LAST);
  assign prog_wr     = prog_valid && prog_ready;
  assign unused_bits = ^{pc[31:INST_MEM_ADDR_SIZE], pc[1:0], funct3[2]};

  core u_core (
    .clk        (clk),
    .rst        (core_rst),
    .pc         (pc),
    .instr      (instr),
    .addr       (addr),
    .write_data (write_data),
    .store_data (store_data),
    .funct3     (funct3),
    .read_data  (read_data)
  );

  // Run-control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_PROG;
    else          state <= state_next;
  end

  // Run-control next state and status outputs; a result store wins over the watchdog.
  always_comb begin
    state_next = state;
    prog_ready = (state == ST_PROG);
    running    = (state == ST_RUN);
    case (state)
      ST_PROG: if (prog_done) state_next = ST_RUN;
      ST_RUN: begin
        if (result_hit)       state_next = ST_DONE;
        else if (timeout_hit) state_next = ST_TIMEOUT;
      end
      default: ;
    endcase
  end

  // Sticky result capture from the tohost store or the watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_valid  <= 1'b0;
      result_passed <= 1'b0;
      result_code   <= '0;
      timeout       <= 1'b0;
    end else if (result_hit) begin
      result_valid  <= 1'b1;
      result_passed <= (store_data == 32'd1);
      result_code   <= store_data[31:1];
    end else if (timeout_hit) begin
      result_valid  <= 1'b1;
      result_passed <= 1'b0;
      result_code   <= '0;
      timeout       <= 1'b1;
    end
  end

  // Saturating count of RUN cycles, including the result cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     cycle_count <= '0;
    else if (state == ST_RUN && cycle_count != '1)   cycle_count <= cycle_count + 32'd1;
  end

  // Store strobe/data alignment; bytes shifted past lane 3 are dropped.
  always_comb begin
    case (funct3[1:0])
      2'd0:    base_strobe = 4'b0001;
      2'd1:    base_strobe = 4'b0011;
      2'd2:    base_strobe = 4'b1111;
      default: base_strobe = 4'b0000;
    endcase
    strobe   = base_strobe << addr[1:0];
    wdata    = store_data << {addr[1:0], 3'b000};
    store_en = write_data && (state == ST_RUN) && !result_hit;
  end

  // Instruction memory programming port (contents survive reset).
  always_ff @(posedge clk) begin
`ifdef RISCV_TEST_HARNESS_DMEM_PROG_EN
    if (prog_wr && !prog_target) imem[prog_addr] <= prog_data;
`else
    if (prog_wr) imem[prog_addr] <= prog_data;
`endif
  end

  // Data memory byte-lane writes from core stores (contents survive reset).
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (strobe[b]) dmem[addr[DATA_MEM_ADDR_SIZE-1:2]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
`ifdef RISCV_TEST_HARNESS_DMEM_PROG_EN
    else if (prog_wr && prog_target) begin
      dmem[prog_addr[DATA_MEM_ADDR_SIZE-3:0]] <= prog_data;
    end
`endif
  end
endmodule
